// File: rtl/float2int_seq_if.sv
// Handshake bundle for the float2int_seq converter: input code channel, result channel and busy flag.
interface float2int_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_float;
   logic        out_valid;
   logic        out_ready;
   logic [10:0] out_int;
   logic        busy;

   modport master (
      output in_valid, in_float, out_ready,
      input  in_ready, out_valid, out_int, busy
   );

   modport slave (
      input  in_valid, in_float, out_ready,
      output in_ready, out_valid, out_int, busy
   );
endinterface

// File: rtl/float2int_seq.sv
// Sequential 7-bit mini-float (3-bit exponent, 4-bit mantissa) to 11-bit unsigned integer converter.
// One left shift per cycle; the result is held in DONE until the consumer takes it.
module float2int_seq (
   input logic      clock,
   input logic      reset,
   float2int_seq_if.slave f
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state;
   logic [10:0] acc;
   logic [2:0]  cnt;
   logic        busy_q;
   logic        out_valid_q;
   logic [10:0] out_int_q;

   logic [2:0]  exp_in;
   logic [3:0]  mant_in;
   logic [10:0] load_acc;
   logic [2:0]  load_cnt;

   assign exp_in  = f.in_float[6:4];
   assign mant_in = f.in_float[3:0];

   // Denormal codes (e==0) carry no hidden one and need no shifting at all.
   always_comb begin
      load_acc = {7'b0, mant_in};
      load_cnt = 3'd0;
      if (exp_in != 3'd0) begin
         load_acc = {6'b0, 1'b1, mant_in};
         load_cnt = exp_in - 3'd1;
      end
   end

   // Accepting is gated by reset so no code slips in on a reset edge.
   assign f.in_ready  = (state == IDLE) && !reset;
   assign f.busy      = busy_q;
   assign f.out_valid = out_valid_q;
   assign f.out_int   = out_int_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         acc         <= 11'd0;
         cnt         <= 3'd0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_int_q   <= 11'd0;
      end else begin
         case (state)
            IDLE: begin
               if (f.in_valid) begin
                  acc    <= load_acc;
                  cnt    <= load_cnt;
                  busy_q <= 1'b1;
                  if (load_cnt == 3'd0) begin
                     state       <= DONE;
                     out_valid_q <= 1'b1;
                     out_int_q   <= load_acc;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               acc <= acc << 1;
               cnt <= cnt - 3'd1;
               // Last step: publish the shifted value together with the move to DONE.
               if (cnt == 3'd1) begin
                  state       <= DONE;
                  out_valid_q <= 1'b1;
                  out_int_q   <= acc << 1;
               end
            end
            DONE: begin
               if (f.out_ready) begin
                  state       <= IDLE;
                  acc         <= 11'd0;
                  cnt         <= 3'd0;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b0;
                  out_int_q   <= 11'd0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_float2int_seq.sv
// Scoreboard bench for float2int_seq: directed codes, backpressure, mid-conversion reset and a full sweep.
module tb_float2int_seq;

   typedef struct {
      logic [10:0] val;
      int          lat;
   } exp_t;

   logic clock;
   logic reset;
   float2int_seq_if f ();

   float2int_seq dut (
      .clock (clock),
      .reset (reset),
      .f     (f)
   );

   int   tests = 0;
   int   fails = 0;
   int   cycle = 0;
   exp_t expQ[$];

   bit   autoReady  = 1'b1;
   bit   randomMode = 1'b0;

   bit   txActive     = 1'b0;
   bit   acceptNext   = 1'b0;
   bit   transferNext = 1'b0;
   bit   doneSeen     = 1'b0;
   bit   resetPrev    = 1'b1;
   int   acceptCycle  = 0;
   logic [10:0] curVal = '0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cycle++;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cycle);
      end
   endtask

   function automatic exp_t model(input logic [6:0] code);
      exp_t r;
      logic [2:0] e;
      e = code[6:4];
      if (e == 3'd0) begin
         r.val = {7'b0, code[3:0]};
         r.lat = 1;
      end else begin
         r.val = {6'b0, 1'b1, code[3:0]} << (e - 3'd1);
         r.lat = int'(e);
      end
      return r;
   endfunction

   // Monitor: tracks the transaction from the observed handshakes and checks outputs every cycle.
   always @(negedge clock) begin
      exp_t got;
      if (resetPrev) begin
         txActive     = 1'b0;
         acceptNext   = 1'b0;
         transferNext = 1'b0;
         doneSeen     = 1'b0;
         expQ.delete();
      end else begin
         if (transferNext) begin
            txActive = 1'b0;
            doneSeen = 1'b0;
         end
         if (acceptNext) txActive = 1'b1;
      end

      checkOutput("busy", 32'(f.busy), 32'(txActive));
      checkOutput("in_ready", 32'(f.in_ready), 32'(!txActive && !reset));

      if (f.out_valid === 1'b1) begin
         if (!doneSeen) begin
            checkOutput("result_expected", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) begin
               got = expQ.pop_front();
               checkOutput("out_int", 32'(f.out_int), 32'(got.val));
               checkOutput("latency", 32'(cycle - acceptCycle), 32'(got.lat));
               curVal   = got.val;
               doneSeen = 1'b1;
            end
         end else begin
            checkOutput("out_int_hold", 32'(f.out_int), 32'(curVal));
         end
      end else begin
         checkOutput("out_int_zero", 32'(f.out_int), 32'd0);
         if (doneSeen) checkOutput("out_valid_hold", 32'(f.out_valid), 32'd1);
      end

      acceptNext   = (f.in_valid === 1'b1) && (f.in_ready === 1'b1) && !reset;
      transferNext = (f.out_valid === 1'b1) && (f.out_ready === 1'b1) && !reset;
      if (acceptNext) acceptCycle = cycle;
      resetPrev = reset;
   end

   // Consumer: always ready, or randomly stalling, unless a test takes manual control.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (autoReady) f.out_ready = randomMode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic applyStimulus(input logic [6:0] code, input logic [10:0] val, input int lat, input bit hold);
      exp_t e;
      bit   accepted;
      @(posedge clock);
      #1;
      f.in_valid = 1'b1;
      f.in_float = code;
      e.val = val;
      e.lat = lat;
      expQ.push_back(e);
      accepted = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (f.in_ready === 1'b1) begin
            accepted = 1'b1;
            break;
         end
      end
      if (!accepted) checkOutput("accept_timeout", 32'(accepted), 32'd1);
      @(posedge clock);
      #1;
      if (!hold) begin
         f.in_valid = 1'b0;
         f.in_float = 7'($urandom);
      end
   endtask

   task automatic waitIdle();
      bit idle;
      idle = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clock);
         #2;
         if (!txActive && !acceptNext && expQ.size() == 0) begin
            idle = 1'b1;
            break;
         end
      end
      if (!idle) checkOutput("drain_timeout", 32'(idle), 32'd1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      exp_t m;
      bit   seen;
      reset       = 1'b1;
      f.in_valid  = 1'b0;
      f.in_float  = 7'd0;
      f.out_ready = 1'b1;

      @(negedge clock);
      checkOutput("reset_out_valid", 32'(f.out_valid), 32'd0);
      checkOutput("reset_out_int", 32'(f.out_int), 32'd0);
      checkOutput("reset_busy", 32'(f.busy), 32'd0);
      checkOutput("reset_in_ready", 32'(f.in_ready), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      checkOutput("post_reset_in_ready", 32'(f.in_ready), 32'd1);

      applyStimulus(7'b000_1001, 11'd9, 1, 1'b0);
      waitIdle();
      applyStimulus(7'b001_0000, 11'd16, 1, 1'b0);
      waitIdle();
      applyStimulus(7'b011_0101, 11'd84, 3, 1'b0);
      waitIdle();
      applyStimulus(7'b111_1111, 11'd1984, 7, 1'b0);
      waitIdle();
      applyStimulus(7'b000_0000, 11'd0, 1, 1'b0);
      waitIdle();
      applyStimulus(7'b111_0000, 11'd1024, 7, 1'b0);
      waitIdle();

      // Backpressure, then a held in_valid picked up right after the transfer.
      autoReady   = 1'b0;
      f.out_ready = 1'b0;
      applyStimulus(7'b010_0011, 11'd38, 2, 1'b1);
      f.in_float = 7'b000_0101;
      m.val = 11'd5;
      m.lat = 1;
      expQ.push_back(m);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (f.out_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("bp_reach_done", 32'(seen), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         checkOutput("bp_out_int", 32'(f.out_int), 32'd38);
         checkOutput("bp_out_valid", 32'(f.out_valid), 32'd1);
      end
      @(posedge clock);
      #1;
      f.out_ready = 1'b1;
      @(posedge clock);
      #1;
      @(negedge clock);
      checkOutput("bp_idle_busy", 32'(f.busy), 32'd0);
      checkOutput("bp_next_accept_ready", 32'(f.in_ready), 32'd1);
      @(posedge clock);
      #1;
      f.in_valid = 1'b0;
      @(negedge clock);
      checkOutput("bp_second_valid", 32'(f.out_valid), 32'd1);
      autoReady = 1'b1;
      waitIdle();

      // Reset in the middle of an e=6 conversion must discard it.
      applyStimulus(7'b110_0001, 11'd544, 6, 1'b0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      @(negedge clock);
      checkOutput("rst_in_ready_low", 32'(f.in_ready), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      checkOutput("rst_in_ready_back", 32'(f.in_ready), 32'd1);
      checkOutput("rst_out_valid", 32'(f.out_valid), 32'd0);
      repeat (10) @(posedge clock);
      applyStimulus(7'b010_1010, 11'd52, 2, 1'b0);
      waitIdle();

      // Every code, with random consumer stalls.
      randomMode = 1'b1;
      for (int c = 0; c < 128; c++) begin
         m = model(7'(c));
         applyStimulus(7'(c), m.val, m.lat, 1'b0);
      end
      waitIdle();
      randomMode = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
